// File: rtl/atm_pkg.sv
// Shared definitions for the ATM front-panel logic.
// Holds the main controller state encoding, the digit-entry FSM state
// encoding, the BCD digit limits and small BCD step helpers.
// No ports (package).
package atm_pkg;

  // Main controller states. The digit-entry block is enabled while the
  // controller sits in CTRL_ACC_NUM or CTRL_PIN_INPUT.
  typedef enum logic [2:0] {
    CTRL_IDLE      = 3'd0,
    CTRL_ACC_NUM   = 3'd1,
    CTRL_PIN_INPUT = 3'd2,
    CTRL_MENU      = 3'd3,
    CTRL_DONE      = 3'd4
  } ctrl_state_t;

  // Digit-entry FSM states.
  typedef enum logic [1:0] {
    ENTRY_IDLE     = 2'd0,
    ENTRY_EDIT     = 2'd1,
    ENTRY_WAIT_ACK = 2'd2
  } entry_state_t;

  localparam logic [3:0] BCD_MIN = 4'd0;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Wrapping BCD increment. Anything at or above 9 lands on 0, so even a
  // corrupted digit is pulled back into range.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
  endfunction

  // Wrapping BCD decrement. 0 (or an out-of-range code) lands on 9.
  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == BCD_MIN || d > BCD_MAX) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counting debouncer and
// press-edge detector.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   btn_raw - raw asynchronous button input
//   level   - debounced button level
//   press   - one-cycle pulse when the debounced level goes 0->1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        // The Nth consecutive differing cycle commits the new level; the
        // press pulse coincides with the level rising.
        if (cnt == CNT_MAX) begin
          level <= sync2;
          press <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Any return to the committed level is a bounce: restart.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/digit_entry.sv
// Multi-digit BCD entry from five push buttons.
// U/D change the digit under the cursor (wrapping 0..9), L/R move the
// cursor (saturating), C confirms. A confirmed value is frozen with valid
// high until the controller acks it.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   enable                    - controller is in an entry state
//   BTNU/BTND/BTNL/BTNR/BTNC  - raw push buttons
//   value_bcd                 - entered digits, digit 0 in [3:0]
//   cursor                    - index of the digit being edited
//   editing                   - high in EDIT (display blinks cursor digit)
//   valid                     - entry complete, value_bcd frozen
//   ack                       - controller consumed value_bcd
//   dbg_state                 - current FSM state, for observation
// Handshake: valid rises one cycle after a confirm and stays high, with
// value_bcd stable, until ack is sampled high; valid drops the next cycle.
module digit_entry
  import atm_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                BTNU,
  input  logic                BTND,
  input  logic                BTNL,
  input  logic                BTNR,
  input  logic                BTNC,
  output logic [4*DIGITS-1:0] value_bcd,
  output logic [2:0]          cursor,
  output logic                editing,
  output logic                valid,
  input  logic                ack,
  output logic [1:0]          dbg_state
);

  localparam logic [2:0] CURSOR_MAX = 3'(DIGITS - 1);

  entry_state_t        state, state_n;
  logic [4*DIGITS-1:0] digits_n;
  logic [2:0]          cursor_n;

  // Button order in these vectors: {C, U, D, L, R}.
  logic [4:0] raw;
  logic [4:0] pressed;
  logic [4:0] lvl_unused;

  assign raw = {BTNC, BTNU, BTND, BTNL, BTNR};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(raw[g]),
      .level  (lvl_unused[g]),
      .press  (pressed[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ENTRY_IDLE;
      value_bcd <= '0;
      cursor    <= 3'd0;
    end else begin
      state     <= state_n;
      value_bcd <= digits_n;
      cursor    <= cursor_n;
    end
  end

  always_comb begin
    state_n  = state;
    digits_n = value_bcd;
    cursor_n = cursor;
    case (state)
      ENTRY_IDLE: begin
        if (enable) begin
          state_n  = ENTRY_EDIT;
          digits_n = '0;
          cursor_n = CURSOR_MAX;
        end
      end
      ENTRY_EDIT: begin
        if (!enable) begin
          state_n  = ENTRY_IDLE;
          digits_n = '0;
        end else if (pressed[4]) begin
          state_n = ENTRY_WAIT_ACK;
        end else if (pressed[3] || pressed[2]) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cursor == 3'(i)) begin
              digits_n[4*i +: 4] = pressed[3] ? bcd_inc(value_bcd[4*i +: 4])
                                              : bcd_dec(value_bcd[4*i +: 4]);
            end
          end
        end else if (pressed[1]) begin
          if (cursor < CURSOR_MAX) cursor_n = cursor + 3'd1;
        end else if (pressed[0]) begin
          if (cursor != 3'd0) cursor_n = cursor - 3'd1;
        end
      end
      ENTRY_WAIT_ACK: begin
        // Presses are ignored here; only enable and ack matter.
        if (!enable) begin
          state_n  = ENTRY_IDLE;
          digits_n = '0;
        end else if (ack) begin
          state_n  = ENTRY_EDIT;
          digits_n = '0;
          cursor_n = CURSOR_MAX;
        end
      end
      default: begin
        state_n  = ENTRY_IDLE;
        digits_n = '0;
      end
    endcase
  end

  assign editing   = (state == ENTRY_EDIT);
  assign valid     = (state == ENTRY_WAIT_ACK);
  assign dbg_state = state;

endmodule

// File: tb/tb_digit_entry.sv
module tb_digit_entry;
  import atm_pkg::*;

  localparam int DIGITS = 4;
  localparam int DB     = 4;
  localparam int W      = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        ack;
  logic [4:0]  btn; // {C, U, D, L, R}
  logic [15:0] value_bcd;
  logic [2:0]  cursor;
  logic        editing;
  logic        valid;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  // bench-side reference model
  logic [1:0]  m_state;
  logic [15:0] m_digits;
  logic [2:0]  m_cursor;

  digit_entry #(
    .DIGITS(DIGITS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .BTNU     (btn[3]),
    .BTND     (btn[2]),
    .BTNL     (btn[1]),
    .BTNR     (btn[0]),
    .BTNC     (btn[4]),
    .value_bcd(value_bcd),
    .cursor   (cursor),
    .editing  (editing),
    .valid    (valid),
    .ack      (ack),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] obs_snap();
    return {9'd0, dbg_state, valid, editing, cursor, value_bcd};
  endfunction

  function automatic logic [W-1:0] model_snap();
    return {9'd0, m_state, (m_state == 2'd2), (m_state == 2'd1), m_cursor, m_digits};
  endfunction

  task automatic push_model();
    exp_q.push_back(model_snap());
  endtask

  task automatic compare_next(input string tag);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check(tag, obs_snap(), exp_q.pop_front());
    end
  endtask

  // reference behaviour of one press event (mask may hold several buttons)
  task automatic model_apply(input logic [4:0] mask);
    logic [3:0] d;
    if (m_state == 2'd1) begin
      d = m_digits[m_cursor*4 +: 4];
      if (mask[4]) m_state = 2'd2;
      else if (mask[3]) m_digits[m_cursor*4 +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
      else if (mask[2]) m_digits[m_cursor*4 +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
      else if (mask[1]) m_cursor = (m_cursor == 3'd3) ? 3'd3 : m_cursor + 3'd1;
      else if (mask[0]) m_cursor = (m_cursor == 3'd0) ? 3'd0 : m_cursor - 3'd1;
    end
  endtask

  // drivers
  task automatic press(input logic [4:0] mask);
    @(negedge clk) btn = mask;
    repeat (10) @(negedge clk);
    model_apply(mask);
    btn = 5'd0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_n(input logic [4:0] mask, input int n);
    for (int i = 0; i < n; i++) press(mask);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; ack = 1'b0; btn = 5'd0;
    m_state = 2'd0; m_digits = 16'h0; m_cursor = 3'd0;
    repeat (3) @(negedge clk);
    push_model();
    compare_next("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // enter EDIT
    enable = 1'b1;
    @(negedge clk);
    m_state = 2'd1; m_digits = 16'h0; m_cursor = 3'd3;
    push_model();
    compare_next("enable_to_edit");

    // three clean up presses
    press_n(5'b01000, 3);
    push_model();
    compare_next("up_x3");
    check("up_x3_value", {16'd0, value_bcd}, 32'h3000);

    // ack outside WAIT_ACK is ignored
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    push_model();
    compare_next("ack_in_edit");

    // right x5 saturates at 0
    press_n(5'b00001, 5);
    push_model();
    compare_next("right_sat");
    check("right_sat_cursor", {29'd0, cursor}, 32'd0);

    // down at 0 wraps to 9
    press(5'b00100);
    push_model();
    compare_next("down_wrap");
    check("down_wrap_value", {16'd0, value_bcd}, 32'h3009);

    // left x9 saturates at 3
    press_n(5'b00010, 9);
    push_model();
    compare_next("left_sat");

    // bouncing up button: exactly one increment
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) btn[3] = 1'b1;
      @(negedge clk);
      @(negedge clk) btn[3] = 1'b0;
      @(negedge clk);
    end
    @(negedge clk) btn[3] = 1'b1;
    repeat (10) @(negedge clk);
    model_apply(5'b01000);
    btn = 5'd0;
    repeat (10) @(negedge clk);
    push_model();
    compare_next("bounce_once");
    check("bounce_value", {16'd0, value_bcd}, 32'h4009);

    // clear via enable low/high, then enter 1,2,3,4
    @(negedge clk) enable = 1'b0;
    @(negedge clk) enable = 1'b1;
    m_state = 2'd0; m_digits = 16'h0;
    push_model();
    compare_next("enable_low_clear");
    @(negedge clk);
    m_state = 2'd1; m_cursor = 3'd3;
    press_n(5'b01000, 1);
    press(5'b00001); press_n(5'b01000, 2);
    press(5'b00001); press_n(5'b01000, 3);
    press(5'b00001); press_n(5'b01000, 4);
    press(5'b10000);
    push_model();
    compare_next("confirm_1234");
    check("confirm_value", {16'd0, value_bcd}, 32'h1234);

    // value frozen while BTNU held in WAIT_ACK
    @(negedge clk) btn[3] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("hold_value", {15'd0, valid, value_bcd}, {15'd0, 1'b1, 16'h1234});
    end
    btn = 5'd0;
    repeat (10) @(negedge clk);
    push_model();
    compare_next("hold_after_release");

    // ack returns to EDIT with digits cleared
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    m_state = 2'd1; m_digits = 16'h0; m_cursor = 3'd3;
    push_model();
    compare_next("ack_to_edit");

    // C and U together: confirm only
    press(5'b01000);
    press(5'b11000);
    push_model();
    compare_next("c_beats_u");
    check("c_beats_u_value", {16'd0, value_bcd}, 32'h1000);

    // enable low beats ack in WAIT_ACK
    @(negedge clk) begin enable = 1'b0; ack = 1'b1; end
    @(negedge clk) ack = 1'b0;
    m_state = 2'd0; m_digits = 16'h0;
    push_model();
    compare_next("enable_over_ack");

    // asynchronous reset mid-EDIT
    @(negedge clk) enable = 1'b1;
    @(negedge clk);
    m_state = 2'd1; m_digits = 16'h0; m_cursor = 3'd3;
    press(5'b01000);
    push_model();
    compare_next("pre_reset_edit");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset", obs_snap(), 32'd0);

    // button held through reset gives one pulse after release
    btn[3] = 1'b1;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) @(negedge clk);
    m_state = 2'd1; m_digits = 16'h1000; m_cursor = 3'd3;
    push_model();
    compare_next("held_through_reset");
    btn = 5'd0;
    repeat (12) @(negedge clk);
    push_model();
    compare_next("held_single_pulse");

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
